// File: rtl/pkt_buffer_read_arbiter_if.sv
// Request/data bundle between the per-port tx readers, the packet-buffer RAM read port and
// pkt_buffer_read_arbiter. The master modport is the arbiter's view; the slave modport is the
// requesters plus the RAM.
interface pkt_buffer_read_arbiter_if #(
  parameter int unsigned PORT_NUM = 8
);
  logic [PORT_NUM*16-1:0] iv_pkt_raddr;
  logic [PORT_NUM-1:0]    iv_pkt_rd;
  logic [PORT_NUM-1:0]    ov_pkt_raddr_ack;
  logic [133:0]           ov_pkt_data;
  logic [PORT_NUM-1:0]    ov_pkt_data_wr;
  logic [15:0]            ov_ram_raddr;
  logic                   o_ram_rd;
  logic [133:0]           iv_ram_rdata;
  logic                   i_ram_wr_busy;
  logic [1:0]             ov_arb_state;

  modport master (
    input  iv_pkt_raddr, iv_pkt_rd, iv_ram_rdata, i_ram_wr_busy,
    output ov_pkt_raddr_ack, ov_pkt_data, ov_pkt_data_wr, ov_ram_raddr, o_ram_rd, ov_arb_state
  );

  modport slave (
    output iv_pkt_raddr, iv_pkt_rd, iv_ram_rdata, i_ram_wr_busy,
    input  ov_pkt_raddr_ack, ov_pkt_data, ov_pkt_data_wr, ov_ram_raddr, o_ram_rd, ov_arb_state
  );
endinterface

// File: rtl/pkt_buffer_read_arbiter.sv
// Round-robin arbiter sharing the packet-buffer RAM read port between PORT_NUM output ports.
// One RAM read per grant; returning lines are steered back through a latency-matched tag pipe.
// Optional feature macro: PBRA_HOST_PRIO_EN gives port PORT_NUM-1 strict priority.
// Grants are held off for the first cycle after reset release so the first ack lands on the
// second edge after release.
module pkt_buffer_read_arbiter #(
  parameter int unsigned PORT_NUM   = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  pkt_buffer_read_arbiter_if.master bus
);

  localparam int unsigned PtrW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArb   = 2'b01,
    StBlock = 2'b10
  } arb_state_e;

  arb_state_e          state_q;
  logic                ready_q;
  logic [PORT_NUM-1:0] ack_q;
  logic                ram_rd_q;
  logic [15:0]         raddr_q;
  logic [PtrW-1:0]     ptr_q;
  logic [PORT_NUM-1:0] tag_q [RD_LATENCY];
  logic [PORT_NUM-1:0] data_wr_q;
  logic [133:0]        data_q;

  logic [PORT_NUM-1:0] elig;
  logic [PORT_NUM-1:0] rr_elig;
  logic [PORT_NUM-1:0] rr_masked;
  logic [PORT_NUM-1:0] rr_pick;
  logic [PORT_NUM-1:0] win_oh;
  logic                any_elig;
  logic                grant;
  logic                host_win;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW-1:0]     ptr_d;
  logic [15:0]         win_addr;

  // Winner selection: host (optional) first, otherwise lowest eligible at/above the pointer,
  // wrapping to the lowest eligible overall.
  always_comb begin
    // A port acked last cycle is still updating its request; masking it avoids a double grant.
    elig     = ready_q ? (bus.iv_pkt_rd & ~ack_q) : '0;
    any_elig = |elig;
    grant    = any_elig & ~bus.i_ram_wr_busy;
    rr_elig  = elig;
`ifdef PBRA_HOST_PRIO_EN
    rr_elig[PORT_NUM-1] = 1'b0;
    host_win            = elig[PORT_NUM-1];
`else
    host_win            = 1'b0;
`endif
    rr_masked = rr_elig & ({PORT_NUM{1'b1}} << ptr_q);
    rr_pick   = (|rr_masked) ? rr_masked : rr_elig;
    win_idx   = '0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (rr_pick[i]) win_idx = PtrW'(i);
    end
    if (host_win) win_idx = PtrW'(PORT_NUM - 1);
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    win_addr        = bus.iv_pkt_raddr[32'(win_idx) * 16 +: 16];
`ifdef PBRA_HOST_PRIO_EN
    // Host grants leave the pointer alone; it only cycles over ports 0..PORT_NUM-2.
    if (host_win) begin
      ptr_d = ptr_q;
    end else begin
      ptr_d = (32'(win_idx) == PORT_NUM - 2) ? '0 : win_idx + 1'b1;
    end
`else
    ptr_d = (32'(win_idx) == PORT_NUM - 1) ? '0 : win_idx + 1'b1;
`endif
  end

  // Arbitration FSM with registered grant, RAM command and pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      ack_q    <= '0;
      ram_rd_q <= 1'b0;
      raddr_q  <= '0;
      ptr_q    <= '0;
    end else begin
      ready_q  <= 1'b1;
      ack_q    <= grant ? win_oh : '0;
      ram_rd_q <= grant;
      if (grant) begin
        raddr_q <= win_addr;
        ptr_q   <= ptr_d;
      end
      unique case (state_q)
        StIdle: begin
          if (any_elig) state_q <= bus.i_ram_wr_busy ? StBlock : StArb;
        end
        StArb: begin
          if (!any_elig)                state_q <= StIdle;
          else if (bus.i_ram_wr_busy)   state_q <= StBlock;
        end
        StBlock: begin
          if (!any_elig)                state_q <= StIdle;
          else if (!bus.i_ram_wr_busy)  state_q <= StArb;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag pipe tracks the RAM latency so each returning line is flagged for its requester.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
      data_wr_q <= '0;
      data_q    <= '0;
    end else begin
      tag_q[0] <= ack_q;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      data_wr_q <= tag_q[RD_LATENCY-1];
      data_q    <= bus.iv_ram_rdata;
    end
  end

  assign bus.ov_pkt_raddr_ack = ack_q;
  assign bus.o_ram_rd         = ram_rd_q;
  assign bus.ov_ram_raddr     = raddr_q;
  assign bus.ov_pkt_data      = data_q;
  assign bus.ov_pkt_data_wr   = data_wr_q;
  assign bus.ov_arb_state     = state_q;

endmodule

// File: tb/tb_pkt_buffer_read_arbiter.sv
// Self-checking bench for pkt_buffer_read_arbiter: directed scenarios followed by random
// requester/busy traffic, all compared cycle by cycle against a queue-based reference model.
module tb_pkt_buffer_read_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned L = 2;

  typedef struct {
    int          due;
    int          port;
    logic [15:0] addr;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_buffer_read_arbiter_if #(.PORT_NUM(N)) bus ();

  pkt_buffer_read_arbiter #(
    .PORT_NUM  (N),
    .RD_LATENCY(L)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Requester and RAM environment state.
  logic [15:0]  addr_a [N];
  logic [N-1:0] rd;
  logic         busy;
  logic [16:0]  ram_hist [0:L];

  // Reference model state.
  int           cyc;
  int           m_ptr;
  logic         m_ready;
  logic [N-1:0] m_ack;
  logic         m_ramrd;
  logic [15:0]  m_raddr;
  logic [1:0]   m_state;
  ret_t         exp_q[$];

  function automatic logic [133:0] ram_line(input logic [15:0] a);
    return {6'h2a, a, ~a, a * 16'd3, a ^ 16'ha5c3, a, a, a, a};
  endfunction

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) bus.iv_pkt_raddr[p*16 +: 16] = addr_a[p];
    bus.iv_pkt_rd     = rd;
    bus.i_ram_wr_busy = busy;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   bus.ov_pkt_raddr_ack, '0);
    check({tag, "_ramrd"}, bus.o_ram_rd, '0);
    check({tag, "_raddr"}, bus.ov_ram_raddr, '0);
    check({tag, "_wr"},    bus.ov_pkt_data_wr, '0);
    check({tag, "_data"},  bus.ov_pkt_data, '0);
    check({tag, "_state"}, bus.ov_arb_state, '0);
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_ready = 1'b0;
    m_ack   = '0;
    m_ramrd = 1'b0;
    m_raddr = '0;
    m_state = 2'b00;
    exp_q.delete();
  endtask

  // Hold reset across n edges, checking outputs; release half a cycle before the next edge.
  task automatic reset_for(input int n);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (n) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance one clock: predict from the current inputs, compare after the edge, feed the RAM.
  task automatic step();
    logic [N-1:0] elig;
    logic [N-1:0] exp_wr;
    logic [159:0] junk;
    int           w;
    ret_t         r;
    elig    = m_ready ? (rd & ~m_ack) : '0;
    m_ack   = '0;
    m_ramrd = 1'b0;
    cyc++;
    if (elig != 0 && !busy) begin
      w = -1;
`ifdef PBRA_HOST_PRIO_EN
      if (elig[N-1]) begin
        w = N - 1;
      end else begin
        for (int i = 0; i < N - 1; i++)
          if (w < 0 && elig[(m_ptr + i) % (N - 1)]) w = (m_ptr + i) % (N - 1);
        m_ptr = (w + 1) % (N - 1);
      end
`else
      for (int i = 0; i < N; i++)
        if (w < 0 && elig[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      m_ptr = (w + 1) % N;
`endif
      m_ack[w] = 1'b1;
      m_ramrd  = 1'b1;
      m_raddr  = addr_a[w];
      r.due    = cyc + L + 1;
      r.port   = w;
      r.addr   = addr_a[w];
      exp_q.push_back(r);
    end
    m_state = (elig == 0) ? 2'b00 : (busy ? 2'b10 : 2'b01);
    m_ready = 1'b1;

    @(posedge clk);
    #1;
    exp_wr = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_wr[r.port] = 1'b1;
      check("data", bus.ov_pkt_data, ram_line(r.addr));
    end
    check("ack",     bus.ov_pkt_raddr_ack, m_ack);
    check("ram_rd",  bus.o_ram_rd, m_ramrd);
    check("raddr",   bus.ov_ram_raddr, m_raddr);
    check("state",   bus.ov_arb_state, m_state);
    check("data_wr", bus.ov_pkt_data_wr, exp_wr);

    for (int i = L; i > 0; i--) ram_hist[i] = ram_hist[i-1];
    ram_hist[0] = {bus.o_ram_rd, bus.ov_ram_raddr};
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.iv_ram_rdata = ram_hist[L][16] ? ram_line(ram_hist[L][15:0]) : junk[133:0];
  endtask

  task automatic idle_steps(input int n);
    rd = '0;
    busy = 1'b0;
    drive();
    repeat (n) step();
  endtask

  initial begin
    bit seen;
    cyc  = 0;
    rd   = '0;
    busy = 1'b0;
    for (int p = 0; p < N; p++) addr_a[p] = '0;
    for (int i = 0; i <= L; i++) ram_hist[i] = '0;
    bus.iv_ram_rdata = '0;
    drive();
    model_reset();

    // Reset with every port requesting; first ack on port 0 at the second edge after release.
    rst_n = 1'b0;
    rd = '1;
    for (int p = 0; p < N; p++) addr_a[p] = 16'(p * 16'h0011);
    drive();
    reset_for(3);
    step();
    check("t1_no_ack_first_edge", bus.ov_pkt_raddr_ack, '0);
    step();
    check("t1_first_ack_port0", bus.ov_pkt_raddr_ack, 8'h01);
    repeat (8) step();
    idle_steps(5);

    // Round robin among ports 1, 3, 6 holding fixed addresses.
    rd = 8'b0100_1010;
    addr_a[1] = 16'h0010;
    addr_a[3] = 16'h0030;
    addr_a[6] = 16'h0060;
    drive();
    repeat (12) step();
    idle_steps(5);

    // Single port advancing its address after each ack.
    rd = 8'b0000_0100;
    addr_a[2] = 16'h0100;
    drive();
    repeat (10) begin
      step();
      if (m_ack[2]) begin
        addr_a[2] = addr_a[2] + 16'd1;
        drive();
      end
    end
    idle_steps(5);

    // Write side owns the RAM for 5 cycles while port 4 waits.
    rd = 8'b0001_0000;
    addr_a[4] = 16'h0444;
    busy = 1'b1;
    drive();
    repeat (5) step();
    check("t4_block_state", bus.ov_arb_state, 2'b10);
    busy = 1'b0;
    drive();
    step();
    check("t4_ack_after_busy", bus.ov_pkt_raddr_ack, 8'h10);
    rd = '0;
    drive();
    repeat (5) step();

    // Reset one cycle after an ack: the read in flight must not return.
    rd = 8'b0010_0000;
    addr_a[5] = 16'h0555;
    drive();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = m_ack[5];
    end
    check("t5_ack_seen", bus.ov_pkt_raddr_ack[5], 1'b1);
    rd = '0;
    drive();
    step();
    reset_for(1);
    repeat (6) step();

    // Host port 7 against port 0.
    rd = 8'b1000_0001;
    addr_a[0] = 16'h0a00;
    addr_a[7] = 16'h0a07;
    drive();
    repeat (12) step();
    idle_steps(5);

    // Random traffic with random write-side busy.
    repeat (400) begin
      for (int p = 0; p < N; p++) begin
        if (m_ack[p]) begin
          if ($urandom_range(1, 0) == 0) rd[p] = 1'b0;
          else addr_a[p] = 16'($urandom);
        end else if (!rd[p] && $urandom_range(2, 0) == 0) begin
          rd[p]     = 1'b1;
          addr_a[p] = 16'($urandom);
        end
      end
      busy = ($urandom_range(3, 0) == 0);
      drive();
      step();
    end
    idle_steps(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
